hilo_muldiv_sequencer: RTL and testbench
========================================

Name: hilo_muldiv_sequencer

Overview:
- Iterative multiply/divide controller for the EX stage. It owns the HI/LO registers and sequences MULT/MULTU/DIV/DIVU over multiple cycles.
- It raises a stall request when a HI/LO read (MFHI/MFLO) reaches EX while an operation is in flight.
- It sits beside the ALU and is fed from the same forwarded operand muxes as the ALU.

Parameters:
- WIDTH, 32, operand and HI/LO register width
- CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- start  input  1  EX-stage valid mul/div instruction; single-cycle pulse
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- operand_a  input  WIDTH  rs value (multiplicand / dividend), post-forwarding
- operand_b  input  WIDTH  rt value (multiplier / divisor), post-forwarding
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wr_data  input  WIDTH  MTHI/MTLO data
- hi_lo_read  input  1  MFHI/MFLO currently in EX
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight (state != IDLE)
- done  output  1  one-cycle pulse; HI/LO hold the new result
- div_zero  output  1  sticky flag: last DIV/DIVU had divisor 0; cleared on next start
- stall_req  output  1  hold IF/ID/EX, bubble MEM

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; hi, lo, counter and internal accumulators all 0; busy=0, done=0, div_zero=0, stall_req=0. Reset mid-operation aborts immediately and does not update HI/LO.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 at a rising edge latches the operands, records the signs (signed ops only), converts operands to magnitudes, clears the counter, clears div_zero, and goes to RUN.
- RUN: one iteration per cycle.
  - Multiply: shift-add. If the multiplier LSB is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator, then shift right by 1.
  - Divide: restoring. Shift the {rem, quo} pair left by 1, trial-subtract the divisor, keep the difference if it is non-negative, and set the quotient LSB.
  - The counter increments each cycle. Go to FIX after exactly WIDTH RUN cycles.
- FIX: one cycle. Apply sign correction and write HI/LO at the exiting edge.
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Result mapping: HI=product[2W-1:W] or remainder; LO=product[W-1:0] or quotient.
  - Divisor 0: HI=dividend, LO=all ones (the natural restoring output), and div_zero is set.
- DONE: done=1 for this single cycle; hi/lo already show the result. Return to IDLE unconditionally.
- Latency: start sampled at edge t0; done high during cycle t0+WIDTH+2, i.e. 34 cycles at WIDTH=32.
- start while busy: ignored. The pipeline guarantees this cannot occur legitimately.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wr_data at the edge.
  - If start and hi_we/lo_we are both high in the same IDLE cycle, the write is applied and the later FIX result overwrites it.
  - In RUN/FIX/DONE, hi_we/lo_we are ignored.
- stall_req = hi_lo_read AND (state is RUN or FIX), combinational. It is low in DONE, so MFHI reads the fresh value in the done cycle.
- Signed magnitude of the most-negative value (0x80000000) is handled as an unsigned WIDTH-bit magnitude. No overflow flag; DIV of most-negative by -1 yields LO=0x80000000, HI=0.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN
- Defined:
  - MULT/MULTU leave RUN for FIX as soon as the remaining multiplier bits are all zero, after at least 1 RUN cycle.
  - The accumulator is shifted right by the number of remaining iterations in FIX, so the result is identical to the full run.
  - Division timing is unchanged.
- Undefined: all operations take the fixed WIDTH RUN cycles.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0x2 -> HI=0x00000001, LO=0xFFFFFFFE, done at cycle 34, busy high cycles 1-34.
- MULT a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, div_zero=0.
- DIVU a=5, b=0 -> HI=5, LO=0xFFFFFFFF, div_zero=1, cleared at next start.
- MULTU 3*7 with hi_lo_read held high -> stall_req high in every RUN/FIX cycle, low at done; HI=0, LO=21. With MULDIV_EARLY_TERM_EN, done arrives at cycle 5 instead of 34.
- Start DIVU, assert reset low at cycle 10 with prior HI/LO=0x1234/0x5678 -> hi=lo=0, busy=0 immediately. After release, hi_we with wr_data=0xAA in IDLE -> hi=0xAA next cycle.

Source files
------------

// File: rtl/hilo_muldiv_sequencer.sv
// rtl/hilo_muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers
// Optional feature macro: MULDIV_EARLY_TERM_EN (multiplies leave RUN once the remaining multiplier bits are zero)
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             hi_lo_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall_req
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;      // multiply: {partial product, multiplier}; divide: {rem, quo}
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               sign_a;   // dividend sign, gives the remainder its sign
  logic               neg_res;  // operand signs differ on a signed op
  logic               b_zero;
`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0]   mplier;   // multiplier bits not yet consumed
`endif

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, trial;
  logic [2*WIDTH-1:0] acc_next, fix_acc, prod;
  logic [WIDTH-1:0]   rem, quo, hi_fix, lo_fix;
  logic               last_iter;

  // Operand magnitudes, one iteration step, and the sign-corrected result
  always_comb begin
    a_mag    = (op[0] && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    b_mag    = (op[0] && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    trial    = rem_sh - {1'b0, opnd};
    if (is_div) begin
      acc_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                              : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
`ifdef MULDIV_EARLY_TERM_EN
    last_iter = (cnt == CNT_W'(WIDTH-1)) || (!is_div && (mplier[WIDTH-1:1] == '0));
    // Skipped iterations would only have shifted, so shift them out in one go
    fix_acc   = is_div ? acc : (acc >> (CNT_W'(WIDTH) - cnt));
`else
    last_iter = (cnt == CNT_W'(WIDTH-1));
    fix_acc   = acc;
`endif
    prod   = neg_res ? -fix_acc : fix_acc;
    rem    = acc[2*WIDTH-1:WIDTH];
    quo    = acc[WIDTH-1:0];
    if (is_div) begin
      hi_fix = sign_a ? -rem : rem;
      lo_fix = b_zero ? {WIDTH{1'b1}} : (neg_res ? -quo : quo);
    end else begin
      hi_fix = prod[2*WIDTH-1:WIDTH];
      lo_fix = prod[WIDTH-1:0];
    end
  end

  // Sequencer FSM with HI/LO ownership and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      neg_res  <= 1'b0;
      b_zero   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
      mplier   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wr_data;
          if (lo_we) lo <= wr_data;
          if (start) begin
            is_div   <= op[1];
            sign_a   <= op[0] & operand_a[WIDTH-1];
            neg_res  <= op[0] & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            b_zero   <= (operand_b == '0);
            opnd     <= op[1] ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            cnt      <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
`ifdef MULDIV_EARLY_TERM_EN
            mplier   <= b_mag;
`endif
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
`ifdef MULDIV_EARLY_TERM_EN
          mplier <= mplier >> 1;
`endif
          if (last_iter) state <= FIX;
        end
        FIX: begin
          hi       <= hi_fix;
          lo       <= lo_fix;
          div_zero <= is_div & b_zero;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Hold the front of the pipe while a HI/LO read waits on an unfinished result
  assign stall_req = hi_lo_read & ((state == RUN) | (state == FIX));

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb/tb_hilo_muldiv_sequencer.sv - randomized self-checking bench for hilo_muldiv_sequencer
module tb_hilo_muldiv_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  operand_a = '0;
  logic [W-1:0]  operand_b = '0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          hi_lo_read = 1'b0;
  logic [W-1:0]  hi, lo;
  logic          busy, done, div_zero, stall_req;

  int n_checks = 0;
  int n_fail   = 0;
  int op_idx   = 0;

  hilo_muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data), .hi_lo_read(hi_lo_read),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural result: 64-bit product, or C-style truncating divide
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o[1]) begin
      p  = o[0] ? 64'(sa * sb) : ({32'b0, a} * {32'b0, b});
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 0) begin
      eh = a;
      el = '1;
    end else if (!o[0]) begin
      el = a / b;
      eh = a % b;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      el = q[31:0];
      eh = r[31:0];
    end
  endfunction

  // Cycles from the start edge to the done cycle
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
    int k;
    k = W;
`ifdef MULDIV_EARLY_TERM_EN
    if (!o[1]) begin
      logic [31:0] m;
      m = (o[0] && b[31]) ? -b : b;
      k = 1;
      while (k < W && (m >> k) != 0) k++;
    end
`endif
    return k + 2;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic rd, input logic mt, input logic [31:0] wv);
    logic [31:0] eh, el, gh, gl, hi1, hi_late;
    logic        gdz, dz1;
    int          lat, dcyc, ndone, nbusy, nstall;
    model(o, a, b, eh, el);
    lat = exp_lat(o, b);
    dcyc = 0; ndone = 0; nbusy = 0; nstall = 0;
    gh = '0; gl = '0; gdz = 1'b0; dz1 = 1'b1; hi1 = '0; hi_late = '0;
    op_idx++;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    hi_lo_read = rd; hi_we = mt; wr_data = wv;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      operand_a = $urandom; operand_b = $urandom;
      wr_data = ~wv;
      if (c == 1) begin dz1 = div_zero; hi1 = hi; end
      if (c == lat - 1) hi_late = hi;
      if (busy) nbusy++;
      if (stall_req) nstall++;
      if (done) begin
        ndone++;
        if (dcyc == 0) begin dcyc = c; gh = hi; gl = lo; gdz = div_zero; end
      end
      if (c >= lat) hi_we = 1'b0;
    end
    hi_lo_read = 1'b0;
    check($sformatf("op%0d done_cycle", op_idx), 64'(dcyc), 64'(lat));
    check($sformatf("op%0d done_pulses", op_idx), 64'(ndone), 64'd1);
    check($sformatf("op%0d busy_cycles", op_idx), 64'(nbusy), 64'(lat));
    check($sformatf("op%0d stall_cycles", op_idx), 64'(nstall), rd ? 64'(lat - 1) : 64'd0);
    check($sformatf("op%0d hi", op_idx), 64'(gh), 64'(eh));
    check($sformatf("op%0d lo", op_idx), 64'(gl), 64'(el));
    check($sformatf("op%0d div_zero", op_idx), 64'(gdz), 64'(o[1] && b == 0));
    check($sformatf("op%0d div_zero_cleared", op_idx), 64'(dz1), 64'd0);
    if (mt) begin
      check($sformatf("op%0d mthi_at_start", op_idx), 64'(hi1), 64'(wv));
      check($sformatf("op%0d mthi_ignored_busy", op_idx), 64'(hi_late), 64'(wv));
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    #1;
    hi_lo_read = 1'b1;
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    check("reset stall_req", 64'(stall_req), 64'd0);
    hi_lo_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, 32'h0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'h5, 1'b0, 1'b0, 32'h0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0, 32'h0);
    run_op(2'b10, 32'h5, 32'h0, 1'b0, 1'b0, 32'h0);
    run_op(2'b00, 32'h3, 32'h7, 1'b1, 1'b0, 32'h0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    run_op(2'b11, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 32'h0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0);
    run_op(2'b00, 32'h9, 32'h9, 1'b0, 1'b1, 32'hDEAD_BEEF);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    @(negedge clk);
    hi_we = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi hi", 64'(hi), 64'h1234);
    check("mtlo lo", 64'(lo), 64'h5678);
    start = 1'b1; op = 2'b10; operand_a = 32'd1000; operand_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-abort busy", 64'(busy), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    hi_we = 1'b1; wr_data = 32'hAA;
    @(negedge clk);
    hi_we = 1'b0;
    check("post-reset mthi hi", 64'(hi), 64'hAA);
    check("post-reset lo", 64'(lo), 64'd0);
    check("post-reset busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("no spurious done", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
